// File: rtl/reorder_buffer.sv
// Circular reorder buffer: allocates tags at issue, captures CDB results and
// retires entries in program order. A mispredicted branch at the head flushes every entry.
module reorder_buffer #(
    parameter int unsigned ROB_SIZE = 8,
    parameter int unsigned ROB_ADDR = 3
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic                rdy_in,

    input  logic                issue_valid,
    input  logic [1:0]          issue_type,
    input  logic [4:0]          issue_rd,
    output logic [ROB_ADDR-1:0] issue_tag,
    output logic                rob_full,

    input  logic                cdb_valid,
    input  logic [ROB_ADDR-1:0] cdb_tag,
    input  logic [31:0]         cdb_value,
    input  logic                cdb_mispredict,
    input  logic [31:0]         cdb_target,

    input  logic [ROB_ADDR-1:0] query_tag_j,
    input  logic [ROB_ADDR-1:0] query_tag_k,
    output logic                query_ready_j,
    output logic                query_ready_k,
    output logic [31:0]         query_value_j,
    output logic [31:0]         query_value_k,

    output logic                commit_valid,
    output logic [1:0]          commit_type,
    output logic [4:0]          commit_rd,
    output logic [31:0]         commit_value,
    output logic [ROB_ADDR-1:0] commit_tag,
    output logic                RS_clear,
    output logic [31:0]         clear_pc
);

    localparam logic [ROB_ADDR:0]   LP_FULL    = (ROB_ADDR + 1)'(ROB_SIZE);
    localparam logic [ROB_ADDR-1:0] LP_PTR_ONE = {{(ROB_ADDR - 1){1'b0}}, 1'b1};
    localparam logic [ROB_ADDR:0]   LP_CNT_ONE = {{ROB_ADDR{1'b0}}, 1'b1};

    logic [ROB_SIZE-1:0] r_busy;
    logic [ROB_SIZE-1:0] r_ready;
    logic [ROB_SIZE-1:0] r_mispredict;
    logic [1:0]          r_type   [ROB_SIZE];
    logic [4:0]          r_rd     [ROB_SIZE];
    logic [31:0]         r_value  [ROB_SIZE];
    logic [31:0]         r_target [ROB_SIZE];

    logic [ROB_ADDR-1:0] r_head;
    logic [ROB_ADDR-1:0] r_tail;
    logic [ROB_ADDR:0]   r_count;

    logic w_commit;
    logic w_flush;
    logic w_issue;
    logic w_cdb_wr;

    assign rob_full  = (r_count == LP_FULL);
    assign issue_tag = r_tail;

    // A flush discards any issue or CDB write arriving in the same cycle.
    always_comb begin
        w_commit = rdy_in & r_busy[r_head] & r_ready[r_head];
        w_flush  = w_commit & r_mispredict[r_head];
        w_issue  = rdy_in & issue_valid & ~rob_full & ~w_flush;
        w_cdb_wr = rdy_in & cdb_valid & r_busy[cdb_tag] & ~w_flush;
    end

    always_comb begin
        if (cdb_valid && (cdb_tag == query_tag_j)) begin
            query_ready_j = 1'b1;
            query_value_j = cdb_value;
        end else begin
            query_ready_j = r_ready[query_tag_j];
            query_value_j = r_value[query_tag_j];
        end
        if (cdb_valid && (cdb_tag == query_tag_k)) begin
            query_ready_k = 1'b1;
            query_value_k = cdb_value;
        end else begin
            query_ready_k = r_ready[query_tag_k];
            query_value_k = r_value[query_tag_k];
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_busy       <= '0;
            r_ready      <= '0;
            r_mispredict <= '0;
            r_head       <= '0;
            r_tail       <= '0;
            r_count      <= '0;
            commit_valid <= 1'b0;
            commit_type  <= '0;
            commit_rd    <= '0;
            commit_value <= '0;
            commit_tag   <= '0;
            RS_clear     <= 1'b0;
            clear_pc     <= '0;
        end else begin
            commit_valid <= w_commit;
            RS_clear     <= w_flush;
            if (w_commit) begin
                commit_type  <= r_type[r_head];
                commit_rd    <= r_rd[r_head];
                commit_value <= r_value[r_head];
                commit_tag   <= r_head;
            end
            if (w_flush) begin
                clear_pc <= r_target[r_head];
                r_busy   <= '0;
                r_head   <= '0;
                r_tail   <= '0;
                r_count  <= '0;
            end else begin
                if (w_cdb_wr) begin
                    r_ready[cdb_tag]      <= 1'b1;
                    r_mispredict[cdb_tag] <= cdb_mispredict;
                end
                if (w_issue) begin
                    r_busy[r_tail]       <= 1'b1;
                    r_ready[r_tail]      <= (issue_type == 2'd3);
                    r_mispredict[r_tail] <= 1'b0;
                    r_tail               <= r_tail + LP_PTR_ONE;
                end
                if (w_commit) begin
                    r_busy[r_head] <= 1'b0;
                    r_head         <= r_head + LP_PTR_ONE;
                end
                if (w_issue && !w_commit) begin
                    r_count <= r_count + LP_CNT_ONE;
                end else if (!w_issue && w_commit) begin
                    r_count <= r_count - LP_CNT_ONE;
                end
            end
        end
    end

    // Payload is only observed through busy/ready, so it needs no reset.
    always_ff @(posedge clk_in) begin
        if (w_issue) begin
            r_type[r_tail]   <= issue_type;
            r_rd[r_tail]     <= issue_rd;
            r_value[r_tail]  <= '0;
            r_target[r_tail] <= '0;
        end
        if (w_cdb_wr) begin
            r_value[cdb_tag]  <= cdb_value;
            r_target[cdb_tag] <= cdb_target;
        end
    end

endmodule

// File: doc/reorder_buffer.md
# reorder_buffer

Circular reorder buffer for the Tomasulo RISC-V core. It allocates RoB tags to instructions as they issue and records results broadcast on the CDB (common data bus, the result broadcast bus). It retires entries in program order, one per cycle, to the register file and the load/store buffer. On a branch mispredict it raises `RS_clear` and flushes itself, which also flushes the reservation station and the other speculative structures.

## Interface
- `ROB_SIZE`, 8: entry count; must be a power of two.
- `ROB_ADDR`, 3: tag width; equals log2(`ROB_SIZE`).

Ports:
- `clk_in`  in  1  system clock; every register is updated on its rising edge.
- `rst_in`  in  1  reset; asynchronous and active-low.
- `rdy_in`  in  1  global ready; when low, the block is paused.
- `issue_valid`  in  1  an instruction is issuing this cycle.
- `issue_type`  in  2  0 = register write, 1 = branch, 2 = store, 3 = no writeback.
- `issue_rd`  in  5  destination register number.
- `issue_tag`  out  `ROB_ADDR`  tag granted to the issuing instruction; equals `tail`.
- `rob_full`  out  1  high when count == `ROB_SIZE`.
- `cdb_valid`  in  1  a result is on the CDB.
- `cdb_tag`  in  `ROB_ADDR`  tag of the broadcast result.
- `cdb_value`  in  32  result value.
- `cdb_mispredict`  in  1  the broadcast branch was mispredicted.
- `cdb_target`  in  32  correct next PC for a mispredicted branch.
- `query_tag_j`, `query_tag_k`  in  `ROB_ADDR`  operand lookups from issue.
- `query_ready_j`, `query_ready_k`  out  1  the queried entry's value is available.
- `query_value_j`, `query_value_k`  out  32  the queried entry's value.
- `commit_valid`  out  1  one-cycle pulse marking a retirement.
- `commit_type`  out  2  type of the retired entry.
- `commit_rd`  out  5  destination register of the retired entry.
- `commit_value`  out  32  value of the retired entry.
- `commit_tag`  out  `ROB_ADDR`  tag of the retired entry.
- `RS_clear`  out  1  one-cycle flush pulse to all speculative units.
- `clear_pc`  out  32  redirect PC; valid while `RS_clear` is high.

## Operation
- Per-entry state: `busy`, `ready`, `type`, `rd`, `value`, `mispredict`, `target`.
- Pointers: `head` and `tail`, each `ROB_ADDR` bits, wrapping modulo `ROB_SIZE`. A `count` register of `ROB_ADDR`+1 bits tracks occupancy.
- Issue: on `issue_valid` with `rob_full` low, write entry[`tail`] with `busy`=1 and `ready`=0, then increment `tail`.
  - If `issue_type` is 3, the entry is written with `ready`=1 immediately.
  - `issue_valid` while full is ignored; the issuer must not do this.
- CDB write: on `cdb_valid` with entry[`cdb_tag`].`busy` set, set `ready`=1 and capture `value`, `mispredict` and `target`.
  - A CDB write to a non-busy entry is ignored.
- Commit: when entry[`head`] is busy and ready (registered state), perform exactly one of:
  - No mispredict: pulse `commit_valid` with that entry's fields, clear its `busy` bit, and increment `head`.
  - Branch with `mispredict`=1: pulse `RS_clear` and set `clear_pc` to the entry's `target`. Also pulse `commit_valid` so the branch's `rd` (a JAL/JALR link register) is written. Then flush: clear every `busy` bit and set `head`, `tail` and `count` to 0. An issue or CDB write in the same cycle is discarded.
- Count update: `count` changes by +1 for an issue, −1 for a commit, and 0 when both happen.
  - `rob_full` is evaluated from registered `count`, so an issue is blocked when full even if a commit happens in the same cycle.
- Query (combinational) returns the first of these that applies:
  - The CDB is valid this cycle with `cdb_tag` equal to the query tag: ready=1, value=`cdb_value` (CDB bypass).
  - Otherwise: ready and value are the entry's stored `ready` and `value`.
- `rdy_in` low: no state changes. `commit_valid` and `RS_clear` are driven low for that cycle.

## Timing
- Reset values: every `busy` and `ready` bit is 0; `head`, `tail` and `count` are 0.
  - Outputs after reset: `commit_valid`=0, `RS_clear`=0, `clear_pc`=0, `commit_*`=0, `rob_full`=0, `issue_tag`=0.
- Reset asserted mid-operation clears all of the above asynchronously. The first issue after release receives tag 0.
- `commit_*` and `RS_clear` are registered outputs: each is high for the one cycle after the clock edge on which the commit decision is made.
- Latency: a CDB write at edge N lets that entry commit at edge N+1 if it is at `head`. Outputs are visible during cycle N+1.
- Throughput: at most 1 issue, 1 CDB write and 1 commit per cycle.
- Wrap-around: after tag `ROB_SIZE`−1, the next tag issued is 0.
- Timing of `rob_full`:
  - It goes high in the cycle after the issue that brings `count` to `ROB_SIZE`.
  - It goes low in the cycle after the next commit.
- Flush: after an edge with `RS_clear` high, the next issue receives tag 0.

## Test plan
- Reset, then issue 3 register writes (rd = 1, 2, 3). Respond on the CDB in reverse tag order (2, 1, 0) with values 0x30, 0x20, 0x10. Expect in-order commits rd 1/2/3 with values 0x10/0x20/0x30 on consecutive cycles.
- Issue 8 entries: `rob_full`=1, and a 9th `issue_valid` is ignored. Complete tag 0 and let it commit: `rob_full` drops. The next issue gets tag 0 (wrap-around).
- Issue a branch at tag 0 and a register write at tag 1. Broadcast tag 0 with mispredict=1 and target 0x1000. Expect `RS_clear`=1 and `clear_pc`=0x1000 for one cycle, `count`=0, and tag 1 never commits.
- Drive `query_tag_j`=2 in the same cycle as a CDB broadcast of tag 2 with value 0xABCD: `query_ready_j`=1 and `query_value_j`=0xABCD combinationally.
- Hold `rdy_in` low with the head entry ready: no commit happens and state is frozen. Raise `rdy_in`: the commit occurs on the next edge.
- Assert `rst_in` low asynchronously between clock edges while 5 entries are valid. All outputs clear immediately, and after release the first issue gets tag 0.
